// File: rtl/ntt_stream_io.sv
// Streaming load/unload controller for the banked NTT coefficient memory.
// Loads a polynomial, launches the core, then streams the result back out.
module ntt_stream_io #(
    parameter int D_width = 17,
    parameter int BN      = 16,
    parameter int DEGREE  = 4096,
    parameter int MA      = DEGREE / BN,
    parameter int AW      = $clog2(MA),
    parameter int CW      = $clog2(DEGREE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [D_width-1:0]    modulus,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [D_width-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [D_width-1:0]    out_data,
    output logic                  start,
    input  logic                  done,
    output logic                  mem_wr_en,
    output logic [$clog2(BN)-1:0] mem_wr_bank,
    output logic [AW-1:0]         mem_wr_addr,
    output logic [D_width-1:0]    mem_wr_data,
    output logic                  mem_rd_en,
    output logic [$clog2(BN)-1:0] mem_rd_bank,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [D_width-1:0]    mem_rd_data,
    output logic                  busy,
    output logic                  range_err
);
    localparam int BW = $clog2(BN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        UNLOAD
    } state_t;

    state_t             state;
    logic [CW-1:0]      wr_cnt;
    logic [CW-1:0]      rd_cnt;
    logic [CW-1:0]      out_cnt;
    logic               rd_pend;
    logic [1:0]         sk_cnt;
    logic [D_width-1:0] sk_head;
    logic [D_width-1:0] sk_tail;

    logic               in_hs;
    logic               out_hs;
    logic               in_lt_q;
    logic               in_over;
    logic [D_width-1:0] in_diff;
    logic [D_width-1:0] in_red;
    logic [2:0]         occ_next;
    logic               rd_issue;

    assign in_hs   = in_valid & in_ready;
    assign out_hs  = out_valid & out_ready;

    // Single conditional subtract; inputs at or above 2q are flagged.
    assign in_lt_q = in_data < modulus;
    assign in_over = {1'b0, in_data} >= {modulus, 1'b0};
    assign in_diff = in_data - modulus;
    assign in_red  = in_lt_q ? in_data : in_diff;

    assign out_valid = sk_cnt != 2'd0;
    assign out_data  = sk_head;

    // Issue only if the word landing next cycle fits without a pop then.
    assign occ_next = {1'b0, sk_cnt} + {2'b0, rd_pend} - {2'b0, out_hs};
    assign rd_issue = (state == UNLOAD)
                    && (rd_cnt < CW'(DEGREE))
                    && (occ_next <= 3'd1);

    assign mem_rd_en   = rd_issue;
    assign mem_rd_bank = rd_cnt[BW-1:0];
    assign mem_rd_addr = rd_cnt[BW +: AW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            rd_pend     <= 1'b0;
            sk_cnt      <= '0;
            sk_head     <= '0;
            sk_tail     <= '0;
            in_ready    <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            range_err   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_bank <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= in_hs;
            start     <= 1'b0;
            rd_pend   <= rd_issue;
            if (in_hs) begin
                mem_wr_bank <= wr_cnt[BW-1:0];
                mem_wr_addr <= wr_cnt[BW +: AW];
                mem_wr_data <= in_red;
                if (in_over)
                    range_err <= 1'b1;
            end
            if (rd_issue)
                rd_cnt <= rd_cnt + CW'(1);

            case ({rd_pend, out_hs})
                2'b10: begin
                    if (sk_cnt == 2'd0)
                        sk_head <= mem_rd_data;
                    else
                        sk_tail <= mem_rd_data;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk_head <= sk_tail;
                    sk_cnt  <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        sk_head <= mem_rd_data;
                    end else begin
                        sk_head <= sk_tail;
                        sk_tail <= mem_rd_data;
                    end
                end
                default: ;
            endcase

            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        wr_cnt <= CW'(1);
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        if (wr_cnt == CW'(DEGREE - 1)) begin
                            wr_cnt   <= '0;
                            in_ready <= 1'b0;
                            state    <= START;
                        end else begin
                            wr_cnt <= wr_cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    start <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (done)
                        state <= UNLOAD;
                end
                UNLOAD: begin
                    if (out_hs) begin
                        if (out_cnt == CW'(DEGREE - 1)) begin
                            out_cnt  <= '0;
                            rd_cnt   <= '0;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_stream_io.sv
// Scoreboard bench for ntt_stream_io with a small banked memory model.
// Writes and output words are predicted at stimulus time and checked on arrival.
module tb_ntt_stream_io;
    localparam int DW  = 18;
    localparam int BN  = 16;
    localparam int DEG = 64;
    localparam int MA  = 4;
    localparam int AW  = 2;
    localparam logic [DW-1:0] Q = 18'd65537;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] modulus = Q;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          start;
    logic          done = 1'b0;
    logic          mem_wr_en;
    logic [3:0]    mem_wr_bank;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [3:0]    mem_rd_bank;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          busy;
    logic          range_err;

    ntt_stream_io #(
        .D_width(DW),
        .BN(BN),
        .DEGREE(DEG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .modulus(modulus),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .start(start),
        .done(done),
        .mem_wr_en(mem_wr_en),
        .mem_wr_bank(mem_wr_bank),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en),
        .mem_rd_bank(mem_rd_bank),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .busy(busy),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [BN][MA];

    always @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_wr_bank][mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en)
            mem_rd_data <= mem[mem_rd_bank][mem_rd_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int starts = 0;
    int n_wr = 0;
    int last_wr = 0;
    int n_out = 0;
    int first_v = -1;
    int last_hs = 0;
    int idx = 0;
    bit out_rnd = 1'b0;
    bit busy_chk = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    logic [23:0]   wr_q [$];
    logic [DW-1:0] out_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] red(input logic [DW-1:0] d);
        return (d < Q) ? d : d - Q;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = out_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_wr       = 0;
            prev_stall = 1'b0;
        end else begin
            if (mem_wr_en) begin
                if (wr_q.size() == 0)
                    check("wr_extra", 1, 0);
                else
                    check("wr", {mem_wr_bank, mem_wr_addr, mem_wr_data},
                          wr_q.pop_front());
                n_wr++;
                last_wr = cyc;
            end
            if (mem_wr_en && mem_rd_en)
                check("wr_rd_excl", 1, 0);
            if (start) begin
                starts++;
                check("start_lat", cyc, last_wr + 1);
                check("start_nwr", n_wr, DEG);
                check("start_rd", mem_rd_en, 0);
                check("start_inrdy", in_ready, 0);
                n_wr = 0;
            end
            if (busy_chk) begin
                check("busy_fall", busy, 0);
                busy_chk = 1'b0;
            end
            if (prev_stall)
                check("hold", {out_valid, out_data}, {1'b1, prev_data});
            if (out_valid && first_v < 0)
                first_v = cyc;
            if (out_valid && out_ready) begin
                if (out_q.size() == 0)
                    check("out_extra", 1, 0);
                else
                    check("out", out_data, out_q.pop_front());
                n_out++;
                if (n_out == DEG) begin
                    check("busy_last", busy, 1);
                    busy_chk = 1'b1;
                    last_hs  = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("in_ready_to", 0, 1);
            @(posedge clk);
            #1;
        end else begin
            wr_q.push_back({4'(idx % BN), 2'(idx / BN), red(d)});
            out_q.push_back(red(d));
            idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic rst_checks(input string tag);
        check({tag, "_ctl"},
              {in_ready, out_valid, start, mem_wr_en, mem_rd_en, busy,
               range_err}, 0);
        check({tag, "_wr"}, {mem_wr_bank, mem_wr_addr, mem_wr_data}, 0);
        check({tag, "_rd"}, {mem_rd_bank, mem_rd_addr, out_data}, 0);
    endtask

    task automatic wait_start(input int s0);
        int n = 0;
        while (starts == s0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("start_seen", starts - s0, 1);
    endtask

    task automatic unload(input bit rnd);
        int n = 0;
        out_rnd = rnd;
        n_out   = 0;
        first_v = -1;
        @(posedge clk);
        #1;
        check("run_wait", {busy, in_ready, out_valid, mem_rd_en}, 4'b1000);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("unl_rd", mem_rd_en, 1);
        check("unl_ov0", out_valid, 0);
        @(posedge clk);
        #1;
        check("unl_ov1", out_valid, 0);
        @(posedge clk);
        #1;
        check("unl_ov2", out_valid, 1);
        while ((busy || out_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("unl_left", out_q.size(), 0);
        check("idle", {busy, in_ready}, 2'b01);
        @(posedge clk);
        #1;
        out_rnd = 1'b0;
    endtask

    initial begin
        int s0;
        int gap;
        repeat (2) @(posedge clk);
        #1;
        rst_checks("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rdy", {in_ready, busy}, 2'b10);

        // Back-to-back load of 0..63, done pulses ignored in IDLE and LOAD.
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("done_idle", {busy, mem_rd_en}, 0);
        s0  = starts;
        idx = 0;
        for (int i = 0; i < DEG; i++) begin
            if (i == 10)
                done = 1'b1;
            if (i == 12)
                done = 1'b0;
            send(DW'(i));
        end
        wait_start(s0);
        check("c37", mem[5][2], 37);
        unload(1'b0);
        check("no_bubble", last_hs - first_v, DEG - 1);
        check("start_once_a", starts - s0, 1);

        // Reduction edges and the sticky range flag.
        s0  = starts;
        idx = 0;
        check("rerr0", range_err, 0);
        send(18'd65536);
        send(18'd65537);
        send(18'd70000);
        check("rerr_pre", range_err, 0);
        send(18'd131074);
        check("rerr_post", range_err, 1);
        for (int i = 4; i < DEG; i++)
            send(DW'($urandom_range(0, 131073)));
        wait_start(s0);
        unload(1'b1);
        check("start_once_b", starts - s0, 1);
        check("rerr_sticky", range_err, 1);

        // Input gaps with random output backpressure.
        s0  = starts;
        idx = 0;
        for (int i = 0; i < DEG; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(DW'(i));
        end
        wait_start(s0);
        unload(1'b1);
        check("start_once_c", starts - s0, 1);

        // Reset in the middle of a load restarts at coefficient 0.
        s0  = starts;
        idx = 0;
        for (int i = 0; i < 20; i++)
            send(DW'(1000 + i));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        rst_checks("midrst");
        wr_q.delete();
        out_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_nostart", starts - s0, 0);
        idx = 0;
        for (int i = 0; i < DEG; i++)
            send(DW'(200 + i));
        wait_start(s0);
        unload(1'b0);
        check("no_bubble_d", last_hs - first_v, DEG - 1);
        check("start_once_d", starts - s0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
